// File: rtl/rob_multi_commit_pkg.sv
// Shared definitions for the multi-commit reorder buffer: entry-type
// encodings, default geometry and small classification helpers.
package rob_multi_commit_pkg;

    localparam int ROB_AW_DEF = 4;
    localparam int XLEN_DEF   = 32;
    localparam int RAW_DEF    = 5;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic [1:0] {
        TYPE_OTHER  = 2'd0,
        TYPE_STORE  = 2'd1,
        TYPE_BRANCH = 2'd2,
        TYPE_JALR   = 2'd3
    } rob_type_e;

    // Control-transfer entries may redirect the front end and end a commit group.
    function automatic logic is_ctrl(input rob_type_e t);
        return (t == TYPE_BRANCH) || (t == TYPE_JALR);
    endfunction

    // Entries whose commit writes the register file.
    function automatic logic writes_rf(input rob_type_e t);
        return (t == TYPE_OTHER) || (t == TYPE_JALR);
    endfunction

endpackage

// File: rtl/rob_multi_commit_commit_sel.sv
// Commit selection for the two in-order commit slots of the reorder buffer.
// Slot 0 is the head, slot 1 is head+1. Only slot 0 may raise a flush, at
// most one store retires per cycle, and a control-transfer entry always
// closes the commit group.
module rob_commit_sel
    import rob_multi_commit_pkg::*;
#(
    parameter int ROB_AW = ROB_AW_DEF
) (
    input  logic [ROB_AW:0] count,
    input  rob_type_e       h0_type,
    input  logic            h0_ready,
    input  logic            h0_mispredict,
    input  rob_type_e       h1_type,
    input  logic            h1_ready,
    output logic            commit0,
    output logic            commit1,
    output logic            flush_req
);

    localparam logic [ROB_AW:0] CNT_ZERO = {(ROB_AW + 1){1'b0}};
    localparam logic [ROB_AW:0] CNT_TWO  = {{(ROB_AW - 1){1'b0}}, 2'b10};

    logic slot0_s;

    // Decide which of the two oldest entries retire and whether the head redirects.
    always_comb begin
        slot0_s   = (count != CNT_ZERO) && h0_ready;
        commit0   = FALSE;
        commit1   = FALSE;
        flush_req = FALSE;
        if (slot0_s) begin
            commit0 = TRUE;
            if (is_ctrl(h0_type)) begin
                flush_req = h0_mispredict;
            end else begin
                if ((count >= CNT_TWO) && h1_ready) begin
                    case (h1_type)
                        TYPE_OTHER: commit1 = TRUE;
                        TYPE_STORE: commit1 = (h0_type != TYPE_STORE);
                        default:    commit1 = FALSE;
                    endcase
                end else begin
                    commit1 = FALSE;
                end
            end
        end else begin
            commit0 = FALSE;
        end
    end

endmodule

// File: rtl/rob_multi_commit.sv
// Reorder buffer with in-order allocation, two writeback channels (ALU and
// load/store) and up to two in-order commits per cycle. Occupancy is a
// counter, so all 2**ROB_AW entries are usable. A mispredicted BRANCH/JALR
// at the head produces a registered one-cycle flush and empties the buffer.
// Optional build macro ROB_BYPASS_EN: operand lookups also forward the
// same-cycle writeback data (ALU channel wins over load/store channel).
module rob_multi_commit
    import rob_multi_commit_pkg::*;
#(
    parameter int ROB_AW = ROB_AW_DEF,
    parameter int XLEN   = XLEN_DEF,
    parameter int RAW    = RAW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              iss_valid,
    input  logic [1:0]        iss_type,
    input  logic [RAW-1:0]    iss_dest,
    output logic              iss_ready,
    output logic [ROB_AW-1:0] iss_tag,
    input  logic [ROB_AW-1:0] q1_tag,
    input  logic [ROB_AW-1:0] q2_tag,
    output logic              q1_ready,
    output logic              q2_ready,
    output logic [XLEN-1:0]   q1_data,
    output logic [XLEN-1:0]   q2_data,
    input  logic              wa_valid,
    input  logic [ROB_AW-1:0] wa_tag,
    input  logic [XLEN-1:0]   wa_data,
    input  logic              wa_mispredict,
    input  logic [XLEN-1:0]   wa_target,
    input  logic              wl_valid,
    input  logic [ROB_AW-1:0] wl_tag,
    input  logic [XLEN-1:0]   wl_data,
    output logic [1:0]        bc_valid,
    output logic [ROB_AW-1:0] bc_tag0,
    output logic [ROB_AW-1:0] bc_tag1,
    output logic [XLEN-1:0]   bc_data0,
    output logic [XLEN-1:0]   bc_data1,
    output logic              head_store,
    output logic [ROB_AW-1:0] head_tag,
    output logic [1:0]        cm_valid,
    output logic [RAW-1:0]    cm_dest0,
    output logic [RAW-1:0]    cm_dest1,
    output logic [XLEN-1:0]   cm_data0,
    output logic [XLEN-1:0]   cm_data1,
    output logic              flush,
    output logic [XLEN-1:0]   flush_pc
);

    localparam int DEPTH = 2 ** ROB_AW;
    localparam int CW    = ROB_AW + 1;

    localparam logic [CW-1:0]     CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0]     CNT_DEPTH = CW'(DEPTH);
    localparam logic [ROB_AW-1:0] TAG_ZERO  = {ROB_AW{1'b0}};
    localparam logic [ROB_AW-1:0] TAG_ONE   = {{(ROB_AW - 1){1'b0}}, 1'b1};

    // Entry storage
    rob_type_e         type_r   [DEPTH];
    logic [RAW-1:0]    dest_r   [DEPTH];
    logic [XLEN-1:0]   data_r   [DEPTH];
    logic [XLEN-1:0]   target_r [DEPTH];
    logic [DEPTH-1:0]  ready_r;
    logic [DEPTH-1:0]  mispred_r;

    // Pointers and occupancy
    logic [ROB_AW-1:0] head_r;
    logic [ROB_AW-1:0] tail_r;
    logic [CW-1:0]     count_r;

    // Registered outputs
    logic [1:0]        bc_valid_r;
    logic [ROB_AW-1:0] bc_tag0_r;
    logic [ROB_AW-1:0] bc_tag1_r;
    logic [XLEN-1:0]   bc_data0_r;
    logic [XLEN-1:0]   bc_data1_r;
    logic [1:0]        cm_valid_r;
    logic [RAW-1:0]    cm_dest0_r;
    logic [RAW-1:0]    cm_dest1_r;
    logic [XLEN-1:0]   cm_data0_r;
    logic [XLEN-1:0]   cm_data1_r;
    logic              flush_r;
    logic [XLEN-1:0]   flush_pc_r;

    // Combinational control
    logic [ROB_AW-1:0] head1_s;
    logic              iss_ready_s;
    logic              alloc_s;
    logic              commit0_s;
    logic              commit1_s;
    logic              flush_req_s;
    logic [ROB_AW-1:0] head_step_s;
    logic [CW-1:0]     alloc_ext_s;
    logic [CW-1:0]     commit_ext_s;
    logic              wb_en_s;
    logic              bc0_fire_s;
    logic              bc1_fire_s;
    logic              cm0_fire_s;
    logic              cm1_fire_s;
    logic              q1_ready_s;
    logic              q2_ready_s;
    logic [XLEN-1:0]   q1_data_s;
    logic [XLEN-1:0]   q2_data_s;

    assign head1_s     = head_r + TAG_ONE;
    assign iss_ready_s = (count_r < CNT_DEPTH);
    // A flushing cycle discards the allocation and every writeback it carries.
    assign alloc_s     = rdy && iss_valid && iss_ready_s && !flush_req_s;
    assign wb_en_s     = rdy && !flush_req_s;

    assign head_step_s  = {{(ROB_AW - 1){1'b0}}, commit0_s} + {{(ROB_AW - 1){1'b0}}, commit1_s};
    assign alloc_ext_s  = {{ROB_AW{1'b0}}, alloc_s};
    assign commit_ext_s = {{ROB_AW{1'b0}}, commit0_s} + {{ROB_AW{1'b0}}, commit1_s};

    assign bc0_fire_s = wb_en_s && wa_valid && (type_r[wa_tag] != TYPE_BRANCH);
    assign bc1_fire_s = wb_en_s && wl_valid && (type_r[wl_tag] == TYPE_OTHER);
    assign cm0_fire_s = commit0_s && writes_rf(type_r[head_r]);
    assign cm1_fire_s = commit1_s && (type_r[head1_s] == TYPE_OTHER);

    rob_commit_sel #(
        .ROB_AW (ROB_AW)
    ) u_commit_sel (
        .count         (count_r),
        .h0_type       (type_r[head_r]),
        .h0_ready      (ready_r[head_r]),
        .h0_mispredict (mispred_r[head_r]),
        .h1_type       (type_r[head1_s]),
        .h1_ready      (ready_r[head1_s]),
        .commit0       (commit0_s),
        .commit1       (commit1_s),
        .flush_req     (flush_req_s)
    );

    // Head, tail and occupancy; a flush empties the buffer just past the head.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_r  <= TAG_ZERO;
            tail_r  <= TAG_ZERO;
            count_r <= CNT_ZERO;
        end else if (rdy) begin
            if (flush_req_s) begin
                head_r  <= head1_s;
                tail_r  <= head1_s;
                count_r <= CNT_ZERO;
            end else begin
                head_r  <= head_r + head_step_s;
                tail_r  <= alloc_s ? (tail_r + TAG_ONE) : tail_r;
                count_r <= count_r + alloc_ext_s - commit_ext_s;
            end
        end
    end

    // Entry arrays: writeback capture, then allocation (allocation wins on a tag clash).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                type_r[i]   <= TYPE_OTHER;
                dest_r[i]   <= {RAW{1'b0}};
                data_r[i]   <= {XLEN{1'b0}};
                target_r[i] <= {XLEN{1'b0}};
            end
            ready_r   <= {DEPTH{1'b0}};
            mispred_r <= {DEPTH{1'b0}};
        end else if (wb_en_s) begin
            if (wa_valid) begin
                ready_r[wa_tag] <= 1'b1;
                data_r[wa_tag]  <= wa_data;
                if (is_ctrl(type_r[wa_tag])) begin
                    mispred_r[wa_tag] <= wa_mispredict;
                    target_r[wa_tag]  <= wa_target;
                end
            end
            if (wl_valid) begin
                ready_r[wl_tag] <= 1'b1;
                if (type_r[wl_tag] == TYPE_OTHER) begin
                    data_r[wl_tag] <= wl_data;
                end
            end
            if (alloc_s) begin
                type_r[tail_r]    <= rob_type_e'(iss_type);
                dest_r[tail_r]    <= iss_dest;
                ready_r[tail_r]   <= 1'b0;
                mispred_r[tail_r] <= 1'b0;
            end
        end
    end

    // Broadcast, commit-port and flush output registers; pulses drop while stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bc_valid_r <= 2'b00;
            bc_tag0_r  <= TAG_ZERO;
            bc_tag1_r  <= TAG_ZERO;
            bc_data0_r <= {XLEN{1'b0}};
            bc_data1_r <= {XLEN{1'b0}};
            cm_valid_r <= 2'b00;
            cm_dest0_r <= {RAW{1'b0}};
            cm_dest1_r <= {RAW{1'b0}};
            cm_data0_r <= {XLEN{1'b0}};
            cm_data1_r <= {XLEN{1'b0}};
            flush_r    <= 1'b0;
            flush_pc_r <= {XLEN{1'b0}};
        end else if (rdy) begin
            bc_valid_r <= {bc1_fire_s, bc0_fire_s};
            cm_valid_r <= {cm1_fire_s, cm0_fire_s};
            flush_r    <= flush_req_s;
            if (bc0_fire_s) begin
                bc_tag0_r  <= wa_tag;
                bc_data0_r <= wa_data;
            end
            if (bc1_fire_s) begin
                bc_tag1_r  <= wl_tag;
                bc_data1_r <= wl_data;
            end
            if (cm0_fire_s) begin
                cm_dest0_r <= dest_r[head_r];
                cm_data0_r <= data_r[head_r];
            end
            if (cm1_fire_s) begin
                cm_dest1_r <= dest_r[head1_s];
                cm_data1_r <= data_r[head1_s];
            end
            if (flush_req_s) begin
                flush_pc_r <= target_r[head_r];
            end
        end else begin
            bc_valid_r <= 2'b00;
            cm_valid_r <= 2'b00;
            flush_r    <= 1'b0;
        end
    end

    // Operand lookups from stored state, optionally forwarding same-cycle writebacks.
    always_comb begin
        q1_ready_s = ready_r[q1_tag];
        q1_data_s  = data_r[q1_tag];
        q2_ready_s = ready_r[q2_tag];
        q2_data_s  = data_r[q2_tag];
`ifdef ROB_BYPASS_EN
        if (wa_valid && (wa_tag == q1_tag)) begin
            q1_ready_s = 1'b1;
            q1_data_s  = wa_data;
        end else if (wl_valid && (wl_tag == q1_tag)) begin
            q1_ready_s = 1'b1;
            q1_data_s  = wl_data;
        end else begin
            q1_ready_s = ready_r[q1_tag];
            q1_data_s  = data_r[q1_tag];
        end
        if (wa_valid && (wa_tag == q2_tag)) begin
            q2_ready_s = 1'b1;
            q2_data_s  = wa_data;
        end else if (wl_valid && (wl_tag == q2_tag)) begin
            q2_ready_s = 1'b1;
            q2_data_s  = wl_data;
        end else begin
            q2_ready_s = ready_r[q2_tag];
            q2_data_s  = data_r[q2_tag];
        end
`endif
    end

    assign iss_ready  = iss_ready_s;
    assign iss_tag    = tail_r;
    assign head_tag   = head_r;
    assign head_store = (count_r != CNT_ZERO) && (type_r[head_r] == TYPE_STORE) && !ready_r[head_r];
    assign q1_ready   = q1_ready_s;
    assign q1_data    = q1_data_s;
    assign q2_ready   = q2_ready_s;
    assign q2_data    = q2_data_s;
    assign bc_valid   = bc_valid_r;
    assign bc_tag0    = bc_tag0_r;
    assign bc_tag1    = bc_tag1_r;
    assign bc_data0   = bc_data0_r;
    assign bc_data1   = bc_data1_r;
    assign cm_valid   = cm_valid_r;
    assign cm_dest0   = cm_dest0_r;
    assign cm_dest1   = cm_dest1_r;
    assign cm_data0   = cm_data0_r;
    assign cm_data1   = cm_data1_r;
    assign flush      = flush_r;
    assign flush_pc   = flush_pc_r;

endmodule

// File: tb/tb_rob_multi_commit.sv
// Directed bench for rob_multi_commit (ROB_AW=4, XLEN=32, RAW=5).
module tb_rob_multi_commit;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        iss_valid;
    logic [1:0]  iss_type;
    logic [4:0]  iss_dest;
    logic        iss_ready;
    logic [3:0]  iss_tag;
    logic [3:0]  q1_tag, q2_tag;
    logic        q1_ready, q2_ready;
    logic [31:0] q1_data, q2_data;
    logic        wa_valid;
    logic [3:0]  wa_tag;
    logic [31:0] wa_data;
    logic        wa_mispredict;
    logic [31:0] wa_target;
    logic        wl_valid;
    logic [3:0]  wl_tag;
    logic [31:0] wl_data;
    logic [1:0]  bc_valid;
    logic [3:0]  bc_tag0, bc_tag1;
    logic [31:0] bc_data0, bc_data1;
    logic        head_store;
    logic [3:0]  head_tag;
    logic [1:0]  cm_valid;
    logic [4:0]  cm_dest0, cm_dest1;
    logic [31:0] cm_data0, cm_data1;
    logic        flush;
    logic [31:0] flush_pc;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] T_OTHER  = 2'd0;
    localparam logic [1:0] T_STORE  = 2'd1;
    localparam logic [1:0] T_BRANCH = 2'd2;
    localparam logic [1:0] T_JALR   = 2'd3;

`ifdef ROB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    rob_multi_commit dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .iss_valid(iss_valid), .iss_type(iss_type), .iss_dest(iss_dest),
        .iss_ready(iss_ready), .iss_tag(iss_tag),
        .q1_tag(q1_tag), .q2_tag(q2_tag), .q1_ready(q1_ready), .q2_ready(q2_ready),
        .q1_data(q1_data), .q2_data(q2_data),
        .wa_valid(wa_valid), .wa_tag(wa_tag), .wa_data(wa_data),
        .wa_mispredict(wa_mispredict), .wa_target(wa_target),
        .wl_valid(wl_valid), .wl_tag(wl_tag), .wl_data(wl_data),
        .bc_valid(bc_valid), .bc_tag0(bc_tag0), .bc_tag1(bc_tag1),
        .bc_data0(bc_data0), .bc_data1(bc_data1),
        .head_store(head_store), .head_tag(head_tag),
        .cm_valid(cm_valid), .cm_dest0(cm_dest0), .cm_dest1(cm_dest1),
        .cm_data0(cm_data0), .cm_data1(cm_data1),
        .flush(flush), .flush_pc(flush_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iss_valid = 1'b0; wa_valid = 1'b0; wl_valid = 1'b0; wa_mispredict = 1'b0;
    endtask

    task automatic alloc(input logic [1:0] t, input logic [4:0] d);
        iss_valid = 1'b1; iss_type = t; iss_dest = d;
        tick();
        iss_valid = 1'b0;
    endtask

    task automatic wa(input logic [3:0] t, input logic [31:0] d, input logic m, input logic [31:0] tg);
        wa_valid = 1'b1; wa_tag = t; wa_data = d; wa_mispredict = m; wa_target = tg;
    endtask

    task automatic wl(input logic [3:0] t, input logic [31:0] d);
        wl_valid = 1'b1; wl_tag = t; wl_data = d;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; rdy = 1'b1; idle();
        iss_type = T_OTHER; iss_dest = 5'd0; q1_tag = 4'd0; q2_tag = 4'd0;
        wa_tag = 4'd0; wa_data = 32'd0; wa_target = 32'd0; wl_tag = 4'd0; wl_data = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        chk("rst_iss_ready", iss_ready, 1);
        chk("rst_iss_tag", iss_tag, 0);
        chk("rst_head_tag", head_tag, 0);
        chk("rst_cm_valid", cm_valid, 0);
        chk("rst_bc_valid", bc_valid, 0);
        chk("rst_flush", flush, 0);
        chk("rst_head_store", head_store, 0);
        chk("rst_q1_ready", q1_ready, 0);
        rst = 1'b1;

        // Fill all 16 entries
        for (int i = 0; i < 16; i++) begin
            chk("fill_tag", iss_tag, i);
            chk("fill_ready", iss_ready, 1);
            alloc(T_OTHER, 5'(i + 1));
        end
        chk("full_ready", iss_ready, 0);
        chk("full_tag", iss_tag, 0);
        iss_valid = 1'b1; iss_dest = 5'd31;
        tick();
        iss_valid = 1'b0;
        chk("full_ignore_tag", iss_tag, 0);
        chk("full_ignore_head", head_tag, 0);
        wa(4'd0, 32'hA0, 1'b0, 32'd0);
        tick();
        idle();
        chk("wb0_bc_valid", bc_valid, 2'b01);
        chk("wb0_bc_tag0", bc_tag0, 0);
        chk("wb0_bc_data0", bc_data0, 32'hA0);
        chk("wb0_cm_valid", cm_valid, 0);
        q1_tag = 4'd0;
        #1;
        chk("wb0_q1_ready", q1_ready, 1);
        chk("wb0_q1_data", q1_data, 32'hA0);
        // Commit while full: registered count keeps iss_ready low this cycle
        chk("commit_full_ready", iss_ready, 0);
        iss_valid = 1'b1; iss_dest = 5'd7;
        tick();
        iss_valid = 1'b0;
        chk("c0_cm_valid", cm_valid, 2'b01);
        chk("c0_cm_dest0", cm_dest0, 1);
        chk("c0_cm_data0", cm_data0, 32'hA0);
        chk("c0_head", head_tag, 1);
        chk("c0_iss_ready", iss_ready, 1);
        chk("c0_iss_tag_wrap", iss_tag, 0);
        alloc(T_OTHER, 5'd7);
        chk("refill_tag", iss_tag, 1);
        chk("refill_full", iss_ready, 0);

        // Dual commit of OTHER entries
        do_reset();
        for (int i = 0; i < 5; i++) alloc(T_OTHER, 5'(10 + i));
        wa(4'd0, 32'h100, 1'b0, 32'd0); wl(4'd1, 32'h101);
        tick(); idle();
        chk("t2_bc_valid", bc_valid, 2'b11);
        chk("t2_bc_tag0", bc_tag0, 0);
        chk("t2_bc_data0", bc_data0, 32'h100);
        chk("t2_bc_tag1", bc_tag1, 1);
        chk("t2_bc_data1", bc_data1, 32'h101);
        chk("t2_cm_none", cm_valid, 2'b00);
        wa(4'd2, 32'h102, 1'b0, 32'd0);
        tick(); idle();
        chk("t2_cm_pair", cm_valid, 2'b11);
        chk("t2_cm_dest0", cm_dest0, 10);
        chk("t2_cm_data0", cm_data0, 32'h100);
        chk("t2_cm_dest1", cm_dest1, 11);
        chk("t2_cm_data1", cm_data1, 32'h101);
        chk("t2_head2", head_tag, 2);
        wa(4'd4, 32'h104, 1'b0, 32'd0);
        tick(); idle();
        chk("t2_cm_single", cm_valid, 2'b01);
        chk("t2_cm_dest0_12", cm_dest0, 12);
        chk("t2_head3", head_tag, 3);
        wl(4'd3, 32'h103);
        tick(); idle();
        chk("t2_cm_wait", cm_valid, 2'b00);
        chk("t2_bc_ch1", bc_valid, 2'b10);
        chk("t2_bc_tag1_3", bc_tag1, 3);
        tick();
        chk("t2_cm_pair34", cm_valid, 2'b11);
        chk("t2_dest0_13", cm_dest0, 13);
        chk("t2_data0_103", cm_data0, 32'h103);
        chk("t2_dest1_14", cm_dest1, 14);
        chk("t2_data1_104", cm_data1, 32'h104);
        chk("t2_head5", head_tag, 5);

        // Stores: one per cycle
        alloc(T_STORE, 5'd0);
        alloc(T_STORE, 5'd0);
        alloc(T_OTHER, 5'd20);
        chk("t3_head_store", head_store, 1);
        wl(4'd6, 32'h66);
        tick(); idle();
        chk("t3_bc_none", bc_valid, 2'b00);
        chk("t3_head_store_hold", head_store, 1);
        wl(4'd5, 32'h55);
        tick(); idle();
        chk("t3_head_store_clr", head_store, 0);
        chk("t3_head5", head_tag, 5);
        wa(4'd7, 32'h107, 1'b0, 32'd0);
        tick(); idle();
        chk("t3_one_store", head_tag, 6);
        chk("t3_store_no_cm", cm_valid, 2'b00);
        tick();
        chk("t3_cm_slot1", cm_valid, 2'b10);
        chk("t3_cm_dest1", cm_dest1, 20);
        chk("t3_cm_data1", cm_data1, 32'h107);
        chk("t3_head8", head_tag, 8);

        // Mispredicted branch flush
        do_reset();
        alloc(T_BRANCH, 5'd0);
        for (int i = 1; i < 4; i++) alloc(T_OTHER, 5'(i));
        wa(4'd0, 32'd0, 1'b1, 32'h1000); wl(4'd1, 32'h55);
        tick(); idle();
        chk("t4_bc_branch", bc_valid, 2'b10);
        chk("t4_no_flush_yet", flush, 0);
        iss_valid = 1'b1; iss_type = T_OTHER; iss_dest = 5'd9;
        wa(4'd2, 32'h22, 1'b0, 32'd0);
        tick(); idle();
        chk("t4_flush", flush, 1);
        chk("t4_flush_pc", flush_pc, 32'h1000);
        chk("t4_cm_none", cm_valid, 2'b00);
        chk("t4_head", head_tag, 1);
        chk("t4_tail", iss_tag, 1);
        chk("t4_bc_dropped", bc_valid, 2'b00);
        tick();
        chk("t4_flush_pulse", flush, 0);
        chk("t4_no_commit", cm_valid, 2'b00);
        chk("t4_head_still", head_tag, 1);

        // JALR without misprediction
        alloc(T_JALR, 5'd5);
        alloc(T_OTHER, 5'd6);
        wl(4'd2, 32'h77);
        tick(); idle();
        chk("t5_cm_none", cm_valid, 2'b00);
        wa(4'd1, 32'h2004, 1'b0, 32'h3000);
        tick(); idle();
        chk("t5_bc_jalr", bc_valid, 2'b01);
        chk("t5_bc_data0", bc_data0, 32'h2004);
        tick();
        chk("t5_cm_jalr", cm_valid, 2'b01);
        chk("t5_cm_dest0", cm_dest0, 5);
        chk("t5_cm_link", cm_data0, 32'h2004);
        chk("t5_no_flush", flush, 0);
        chk("t5_head2", head_tag, 2);
        tick();
        chk("t5_cm_next", cm_valid, 2'b01);
        chk("t5_cm_dest0_6", cm_dest0, 6);
        chk("t5_cm_data0_77", cm_data0, 32'h77);
        chk("t5_head3", head_tag, 3);

        // Stall and lookup bypass
        for (int i = 0; i < 3; i++) alloc(T_OTHER, 5'(i + 1));
        rdy = 1'b0;
        iss_valid = 1'b1; wl(4'd3, 32'h33);
        tick(); idle();
        chk("t6_stall_tag", iss_tag, 6);
        chk("t6_stall_bc", bc_valid, 2'b00);
        q2_tag = 4'd3;
        #1;
        chk("t6_stall_q2", q2_ready, 0);
        rdy = 1'b1;
        q1_tag = 4'd5; q2_tag = 4'd4;
        wa(4'd5, 32'hDEAD, 1'b0, 32'd0); wl(4'd4, 32'hBEEF);
        #1;
        chk("t6_q1_ready_same", q1_ready, BYP);
        chk("t6_q2_ready_same", q2_ready, BYP);
        if (BYP) begin
            chk("t6_q1_data_same", q1_data, 32'hDEAD);
            chk("t6_q2_data_same", q2_data, 32'hBEEF);
        end
        tick(); idle();
        #1;
        chk("t6_q1_ready_next", q1_ready, 1);
        chk("t6_q1_data_next", q1_data, 32'hDEAD);
        chk("t6_q2_ready_next", q2_ready, 1);
        chk("t6_q2_data_next", q2_data, 32'hBEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rob_multi_commit.md
Name: rob_multi_commit

Overview:
- Parametrised reorder buffer, successor of the single-commit ROB.
- Sits between issue, the ALU/load-store writeback channels, the register file, the store buffer and pc_reg.
- Allocates entries in order, captures results from two writeback channels and commits up to two entries per cycle in program order.
- Raises a precise flush on a mispredicted branch or jalr; every entry is usable because occupancy is tracked with a counter.

Parameters:
- ROB_AW, 4, log2 of entry count (depth = 2**ROB_AW).
- XLEN, 32, data and pc width.
- RAW, 5, architectural register address width.

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-low
- rdy  input  1  global enable; low = full stall
- iss_valid  input  1  allocate one entry this cycle
- iss_type  input  2  entry type: OTHER/STORE/BRANCH/JALR
- iss_dest  input  RAW  destination register
- iss_ready  output  1  an entry is free (count < depth)
- iss_tag  output  ROB_AW  tag the next allocation receives (= tail)
- q1_tag, q2_tag  input  ROB_AW  operand lookup tags
- q1_ready, q2_ready  output  1  entry value valid
- q1_data, q2_data  output  XLEN  entry value
- wa_valid  input  1  ALU writeback
- wa_tag  input  ROB_AW  ALU writeback tag
- wa_data  input  XLEN  ALU result
- wa_mispredict  input  1  ALU misprediction flag
- wa_target  input  XLEN  ALU correct next pc
- wl_valid  input  1  load/store-buffer writeback
- wl_tag  input  ROB_AW  load/store writeback tag
- wl_data  input  XLEN  load data
- bc_valid  output  2  registered broadcast, one bit per channel
- bc_tag0, bc_tag1  output  ROB_AW  broadcast tags
- bc_data0, bc_data1  output  XLEN  broadcast data
- head_store  output  1  head entry is STORE and not ready
- head_tag  output  ROB_AW  current head
- cm_valid  output  2  registered register-file write ports
- cm_dest0, cm_dest1  output  RAW  commit destination
- cm_data0, cm_data1  output  XLEN  commit data
- flush  output  1  registered one-cycle flush pulse
- flush_pc  output  XLEN  redirect target

Behaviour:
- Reset (rst low, asynchronous): head=tail=count=0, all ready bits 0, every output register 0.
- rdy low: no state change; bc_valid, cm_valid and flush forced 0.
- Allocate when iss_valid and iss_ready: write type and dest, clear ready/mispredict, tail+1 with wrap mod depth.
  - iss_valid while !iss_ready is ignored.
  - iss_ready uses the registered count only; a same-cycle commit does not free a slot.
- Writeback wa: set ready; store data; latch mispredict and target for BRANCH/JALR.
  - Broadcast on channel 0 next cycle, except for BRANCH entries.
- Writeback wl: set ready.
  - OTHER entries store data and broadcast on channel 1 next cycle.
  - STORE entries only become ready.
- wa and wl to the same tag in one cycle is illegal. A writeback seen in cycle N is visible to commit in cycle N+1.
- Commit slot 0: head, when count>0 and head is ready.
  - OTHER and JALR write cm port 0.
  - STORE and BRANCH write nothing.
- Commit slot 1: head+1, only when all of the following hold:
  - slot 0 commits and slot 0 is not BRANCH/JALR;
  - count>=2 and head+1 is ready;
  - head+1 is OTHER, or it is STORE while slot 0 is not STORE (at most one store per cycle).
  - Slot 1 never flushes; a BRANCH/JALR at head+1 waits for the next cycle.
- Flush: when slot 0 is BRANCH/JALR with mispredict=1:
  - flush=1 and flush_pc=target next cycle;
  - head=tail=head+1, count=0;
  - the same-cycle allocation is discarded and its writebacks are dropped.
- Count update: count + alloc - commits, evaluated in the same cycle; full and empty states both reachable.
- Lookups are combinational from the entry arrays.

Optional Feature:
- Macro: ROB_BYPASS_EN.
- Defined: q1/q2 also match the same-cycle wa/wl tag and return the incoming data with ready=1; wa has priority over wl.
- Undefined: lookups see stored state only, so same-cycle writeback data appears one cycle later.

Decomposition:
- Shared package/config: entry-type encodings (TYPE_OTHER=0, TYPE_STORE=1, TYPE_BRANCH=2, TYPE_JALR=3), ROB_AW/XLEN/RAW defaults, True/False constants.
- One natural sub-module, rob_commit_sel: combinational logic taking head/head+1 type and ready plus count, producing the two commit enables and the flush decision.

Test Plan:
- Reset, allocate 16 OTHER (ROB_AW=4) -> iss_ready=0 after 16th, tags 0..15, wrap to 0 on first commit.
- Two OTHER entries tags 3,4 get wa then wl in consecutive cycles -> next cycle cm_valid=2'b11 with dest/data in order.
- Two STOREs at head and head+1, both ready -> only one commits per cycle; head_store=1 while store unready.
- BRANCH at head, wa_mispredict=1, wa_target=0x1000, three younger entries -> flush=1, flush_pc=0x1000, count=0, younger never commit.
- JALR at head, mispredict=0 -> cm port 0 writes link value, no flush; head+1 OTHER ready waits one cycle.
- With ROB_BYPASS_EN, q1_tag=5 with wa_tag=5, data 0xDEAD in same cycle -> q1_ready=1, q1_data=0xDEAD; without macro -> q1_ready=0 that cycle.
